// File: rtl/ps2_key_display.sv
// ps2_key_display: pops PS/2 scan codes (at most 1 byte per 3 cycles, stalls only while ready=0), decodes E0/F0 make/break,
// drives held-key + key-history seven-seg pairs, hex registered 1 cycle after decode; PS2_PRESS_COUNT_EN adds press counter.
module ps2_key_display #(
  parameter int NUM_DIGITS     = 6,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    ready,
  input  logic [7:0]              data,
  input  logic                    overflow,
  output logic                    nextdata_n,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    key_down,
  output logic                    key_ext,
  output logic                    ovf_sticky
);

  localparam int NUM_PAIRS = NUM_DIGITS / 2;
`ifdef PS2_PRESS_COUNT_EN
  // Highest pair is taken by the counter, so history gets one pair fewer.
  localparam int HIST_N = (NUM_PAIRS > 1) ? NUM_PAIRS - 2 : 0;
`else
  localparam int HIST_N = NUM_PAIRS - 1;
`endif
  localparam int HIST_W = (HIST_N > 0) ? HIST_N : 1;
  localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_POP,
    HS_SETTLE
  } hs_state_t;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_E0,
    DEC_F0,
    DEC_E0F0
  } dec_state_t;

  hs_state_t  hs_state_q;
  logic       nextdata_n_q;
  logic [7:0] byte_q;

  dec_state_t dec_state_q, dec_state_d;
  logic [7:0] cur_q, cur_d;
  logic       cur_vld_q, cur_vld_d;
  logic       key_down_q, key_down_d;
  logic       key_ext_q, key_ext_d;
  logic       ovf_q, ovf_d;
  logic [7:0] hist_q [HIST_W];
  logic [7:0] hist_d [HIST_W];
  logic [HIST_W-1:0] hist_vld_q, hist_vld_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
`ifdef PS2_PRESS_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  logic is_make, is_break, ev_ext, same_key;

  // The SETTLE cycle gives the keyboard FIFO time to move its read pointer before ready is trusted again.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hs_state_q   <= HS_IDLE;
      nextdata_n_q <= 1'b1;
      byte_q       <= 8'h00;
    end else begin
      case (hs_state_q)
        HS_IDLE: begin
          if (ready) begin
            byte_q       <= data;
            hs_state_q   <= HS_POP;
            nextdata_n_q <= 1'b0;
          end
        end
        HS_POP: begin
          hs_state_q   <= HS_SETTLE;
          nextdata_n_q <= 1'b1;
        end
        HS_SETTLE: begin
          hs_state_q   <= HS_IDLE;
          nextdata_n_q <= 1'b1;
        end
        default: begin
          hs_state_q   <= HS_IDLE;
          nextdata_n_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    dec_state_d = dec_state_q;
    cur_d       = cur_q;
    cur_vld_d   = cur_vld_q;
    key_down_d  = key_down_q;
    key_ext_d   = key_ext_q;
    ovf_d       = ovf_q | overflow;
    hist_d      = hist_q;
    hist_vld_d  = hist_vld_q;
`ifdef PS2_PRESS_COUNT_EN
    cnt_d       = cnt_q;
`endif
    is_make  = 1'b0;
    is_break = 1'b0;
    ev_ext   = 1'b0;

    if (hs_state_q == HS_POP) begin
      case (dec_state_q)
        DEC_BASE: begin
          if (byte_q == 8'hE0)      dec_state_d = DEC_E0;
          else if (byte_q == 8'hF0) dec_state_d = DEC_F0;
          else                      is_make = 1'b1;
        end
        DEC_E0: begin
          if (byte_q == 8'hF0)      dec_state_d = DEC_E0F0;
          else if (byte_q != 8'hE0) begin
            is_make     = 1'b1;
            ev_ext      = 1'b1;
            dec_state_d = DEC_BASE;
          end
        end
        DEC_F0: begin
          is_break    = 1'b1;
          dec_state_d = DEC_BASE;
        end
        default: begin
          is_break    = 1'b1;
          ev_ext      = 1'b1;
          dec_state_d = DEC_BASE;
        end
      endcase
    end

    same_key = cur_vld_q && (byte_q == cur_q) && (ev_ext == key_ext_q);

    // A make of the key already held is typematic repeat; re-pressing the last released key is not.
    if (is_make && !(key_down_q && same_key)) begin
      if (cur_vld_q && !same_key) begin
        hist_d[0]     = cur_q;
        hist_vld_d[0] = 1'b1;
        for (int i = 1; i < HIST_W; i++) begin
          hist_d[i]     = hist_q[i-1];
          hist_vld_d[i] = hist_vld_q[i-1];
        end
      end
      cur_d      = byte_q;
      cur_vld_d  = 1'b1;
      key_ext_d  = ev_ext;
      key_down_d = 1'b1;
`ifdef PS2_PRESS_COUNT_EN
      cnt_d      = cnt_q + 8'd1;
`endif
    end

    if (is_break && key_down_q && same_key) begin
      key_down_d = 1'b0;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic [13:0] pair_glyph(input logic [7:0] c);
    return {seg7(c[7:4]), seg7(c[3:0])};
  endfunction

  always_comb begin
    hex_d = {NUM_DIGITS{SEG_BLANK}};
    if (key_down_q) begin
      hex_d[13:0] = pair_glyph(cur_q);
    end
    for (int p = 0; p < HIST_N; p++) begin
      if (hist_vld_q[p]) begin
        hex_d[14*(p+1) +: 14] = pair_glyph(hist_q[p]);
      end
    end
`ifdef PS2_PRESS_COUNT_EN
    hex_d[14*(NUM_PAIRS-1) +: 14] = pair_glyph(cnt_q);
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dec_state_q <= DEC_BASE;
      cur_q       <= 8'h00;
      cur_vld_q   <= 1'b0;
      key_down_q  <= 1'b0;
      key_ext_q   <= 1'b0;
      ovf_q       <= 1'b0;
      hist_q      <= '{default: 8'h00};
      hist_vld_q  <= '0;
      hex_q       <= {NUM_DIGITS{SEG_BLANK}};
`ifdef PS2_PRESS_COUNT_EN
      cnt_q       <= 8'h00;
`endif
    end else begin
      dec_state_q <= dec_state_d;
      cur_q       <= cur_d;
      cur_vld_q   <= cur_vld_d;
      key_down_q  <= key_down_d;
      key_ext_q   <= key_ext_d;
      ovf_q       <= ovf_d;
      hist_q      <= hist_d;
      hist_vld_q  <= hist_vld_d;
      hex_q       <= hex_d;
`ifdef PS2_PRESS_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign nextdata_n = nextdata_n_q;
  assign hex        = hex_q;
  assign key_down   = key_down_q;
  assign key_ext    = key_ext_q;
  assign ovf_sticky = ovf_q;

endmodule
